// File: rtl/seg7_hex_encoder.sv
// Active-low 7-segment pattern to hex encoder with a stability filter.
// Classifies each newly accepted stable pattern as digit, blank or illegal.
module seg7_hex_encoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [3:0]       hex_out,
    output logic             on_out,
    output logic             valid,
    output logic             err,
    output logic             change,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [6:0]       sample;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       accepted;

    logic [CNT_W-1:0] cnt_nxt_c;
    logic             accept_c;
    logic [3:0]       dec_hex_c;
    logic             dec_hit_c;
    logic             blank_c;

    // Run-length of identical samples; a full run of a new pattern is accepted once.
    always_comb begin
        cnt_nxt_c = '0;
        if (seg_in == sample) begin
            cnt_nxt_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        accept_c = (cnt == CNT_MAX) && (sample != accepted);
    end

    // Inverse of the hex-to-segment decoder table.
    always_comb begin
        dec_hex_c = 4'h0;
        dec_hit_c = 1'b1;
        blank_c   = (sample == SEG_BLANK);
        case (sample)
            7'b1000000: dec_hex_c = 4'h0;
            7'b1111001: dec_hex_c = 4'h1;
            7'b0100100: dec_hex_c = 4'h2;
            7'b0110000: dec_hex_c = 4'h3;
            7'b0011001: dec_hex_c = 4'h4;
            7'b0010010: dec_hex_c = 4'h5;
            7'b0000010: dec_hex_c = 4'h6;
            7'b1111000: dec_hex_c = 4'h7;
            7'b0000000: dec_hex_c = 4'h8;
            7'b0010000: dec_hex_c = 4'h9;
            7'b0001000: dec_hex_c = 4'hA;
            7'b0000011: dec_hex_c = 4'hB;
            7'b1000110: dec_hex_c = 4'hC;
            7'b0100001: dec_hex_c = 4'hD;
            7'b0000110: dec_hex_c = 4'hE;
            7'b0001110: dec_hex_c = 4'hF;
            default:    dec_hit_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample    <= SEG_BLANK;
            cnt       <= '0;
            accepted  <= SEG_BLANK;
            hex_out   <= 4'h0;
            on_out    <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            change    <= 1'b0;
            err_count <= '0;
        end else begin
            sample <= seg_in;
            cnt    <= cnt_nxt_c;
            change <= accept_c;
            if (accept_c) begin
                accepted <= sample;
                hex_out  <= dec_hex_c;
                on_out   <= dec_hit_c;
                valid    <= dec_hit_c | blank_c;
                err      <= ~(dec_hit_c | blank_c);
                // Each illegal episode is accepted exactly once, so count here.
                if (!(dec_hit_c | blank_c) && (err_count != ERR_MAX)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_hex_encoder.sv
// Randomized and directed bench for seg7_hex_encoder against a run-length model.
// Two instances: STABLE_CYCLES=4/ERR_W=8 and STABLE_CYCLES=1/ERR_W=2.
module tb_seg7_hex_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h7F;

    logic [3:0] hex4, hex1;
    logic       on4, on1, val4, val1, err4, err1, chg4, chg1;
    logic [7:0] ec4;
    logic [1:0] ec1;

    seg7_hex_encoder #(.STABLE_CYCLES(4), .ERR_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .seg_in(seg_in), .hex_out(hex4), .on_out(on4),
        .valid(val4), .err(err4), .change(chg4), .err_count(ec4)
    );

    seg7_hex_encoder #(.STABLE_CYCLES(1), .ERR_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .seg_in(seg_in), .hex_out(hex1), .on_out(on1),
        .valid(val1), .err(err1), .change(chg1), .err_count(ec1)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: run length of the trailing identical samples per instance.
    int         m_need [2] = '{4, 1};
    int         m_emax [2] = '{255, 3};
    int         m_run  [2];
    logic [6:0] m_last [2];
    logic [6:0] m_acc  [2];
    int         e_hex  [2];
    int         e_on   [2];
    int         e_val  [2];
    int         e_err  [2];
    int         e_chg  [2];
    int         e_ec   [2];
    int         pulses4, pulses1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 1;
            m_last[i] = 7'h7F;
            m_acc[i]  = 7'h7F;
            e_hex[i] = 0; e_on[i] = 0; e_val[i] = 0;
            e_err[i] = 0; e_chg[i] = 0; e_ec[i] = 0;
        end
    endtask

    task automatic model_step(input logic [6:0] s);
        for (int i = 0; i < 2; i++) begin
            e_chg[i] = 0;
            if (m_run[i] >= m_need[i] && m_last[i] != m_acc[i]) begin
                int idx;
                idx = -1;
                for (int d = 0; d < 16; d++) if (tbl[d] == m_last[i]) idx = d;
                m_acc[i] = m_last[i];
                e_chg[i] = 1;
                if (idx >= 0) begin
                    e_hex[i] = idx; e_on[i] = 1; e_val[i] = 1; e_err[i] = 0;
                end else if (m_last[i] == 7'h7F) begin
                    e_hex[i] = 0; e_on[i] = 0; e_val[i] = 1; e_err[i] = 0;
                end else begin
                    e_hex[i] = 0; e_on[i] = 0; e_val[i] = 0; e_err[i] = 1;
                    if (e_ec[i] < m_emax[i]) e_ec[i] = e_ec[i] + 1;
                end
            end
            if (s == m_last[i]) begin
                if (m_run[i] < 1000) m_run[i] = m_run[i] + 1;
            end else begin
                m_run[i]  = 1;
                m_last[i] = s;
            end
        end
    endtask

    task automatic compare_all();
        check("hex4", 32'(hex4), e_hex[0]);
        check("on4",  32'(on4),  e_on[0]);
        check("val4", 32'(val4), e_val[0]);
        check("err4", 32'(err4), e_err[0]);
        check("chg4", 32'(chg4), e_chg[0]);
        check("ec4",  32'(ec4),  e_ec[0]);
        check("hex1", 32'(hex1), e_hex[1]);
        check("on1",  32'(on1),  e_on[1]);
        check("val1", 32'(val1), e_val[1]);
        check("err1", 32'(err1), e_err[1]);
        check("chg1", 32'(chg1), e_chg[1]);
        check("ec1",  32'(ec1),  e_ec[1]);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic tick();
        logic [6:0] s;
        s = seg_in;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
        compare_all();
        if (chg4 === 1'b1) pulses4++;
        if (chg1 === 1'b1) pulses1++;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset mid-low-phase and expect cleared outputs before any edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_hex4_async", 32'(hex4), 0);
        check("rst_on4_async", 32'(on4), 0);
        check("rst_ec4_async", 32'(ec4), 0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        pulses4 = 0;
        pulses1 = 0;
    endtask

    initial begin
        int lat;
        model_reset();
        #2;
        compare_all();
        do_reset();

        // Digit 2 after a full run, latency of four edges after first sample.
        lat = 0;
        seg_in = tbl[2];
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (chg4 === 1'b1 && lat == 0) lat = i;
        end
        check("t1_latency", 32'(lat), 5);
        check("t1_hex", 32'(hex4), 2);
        check("t1_pulses", 32'(pulses4), 1);

        // Short glitch of 2 then 1 held.
        do_reset();
        hold(tbl[2], 2);
        lat = 0;
        seg_in = tbl[1];
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (chg4 === 1'b1 && lat == 0) lat = i;
        end
        check("t2_latency", 32'(lat), 5);
        check("t2_hex", 32'(hex4), 1);
        check("t2_pulses", 32'(pulses4), 1);

        // Blank after digit; blank held from reset gives no pulse.
        hold(7'h7F, 8);
        check("t3_on", 32'(on4), 0);
        check("t3_valid", 32'(val4), 1);
        check("t3_pulses", 32'(pulses4), 2);
        do_reset();
        hold(7'h7F, 10);
        check("t3_nopulse4", 32'(pulses4), 0);
        check("t3_nopulse1", 32'(pulses1), 0);

        // Illegal, legal, illegal.
        hold(7'b1010101, 6);
        check("t4_ec_a", 32'(ec4), 1);
        hold(7'b0000000, 6);
        check("t4_hex8", 32'(hex4), 8);
        hold(7'b1100110, 6);
        check("t4_err", 32'(err4), 1);
        check("t4_ec_b", 32'(ec4), 2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            hold(7'b1010101, 2);
            hold(tbl[8], 2);
        end
        check("t4_sat", 32'(ec1), 3);

        // Reset two edges into a stable run restarts the count.
        hold(tbl[5], 2);
        do_reset();
        seg_in = tbl[5];
        for (int i = 0; i < 4; i++) tick();
        check("t5_not_yet", 32'(hex4), 0);
        tick();
        check("t5_hex5", 32'(hex4), 5);

        // Decoder loopback sweep.
        do_reset();
        for (int d = 0; d < 16; d++) begin
            hold(tbl[d], 6);
            check("t6_loop", 32'(hex4), d);
        end
        check("t6_pulses4", 32'(pulses4), 16);
        check("t6_pulses1", 32'(pulses1), 16);

        // Random mix of digits, blanks, illegal codes and glitches.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] p;
            case ($urandom_range(0, 3))
                0, 1:    p = tbl[$urandom_range(0, 15)];
                2:       p = 7'h7F;
                default: p = 7'($urandom);
            endcase
            hold(p, int'($urandom_range(1, 8)));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
